// File: rtl/adder_tree_seq_reducer_pkg.sv
// adder_tree_pkg: shared FSM state type and sizing helpers for the sequential adder-tree reducer
package adder_tree_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REDUCE, ST_DONE} state_t;
  function automatic int levels_of(input int n);
    return $clog2(n);
  endfunction
  function automatic int max1(input int n);
    return n < 1 ? 1 : n;
  endfunction
endpackage

// File: rtl/adder_tree_seq_reducer_if.sv
// adder_tree_seq_reducer_if: operand-vector input and sum output handshakes
interface adder_tree_seq_reducer_if #(parameter int WIDTH = 48, parameter int N_IN = 8);
  import adder_tree_pkg::*;
  localparam int SW = WIDTH + levels_of(N_IN);
  logic in_valid;
  logic in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [SW-1:0] out_sum;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_sum);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_sum);
endinterface

// File: rtl/adder_tree_seq_alu.sv
// adder_tree_seq_alu: the single shared adder, summing slots 2*pair and 2*pair+1
module adder_tree_seq_alu import adder_tree_pkg::*; #(
  parameter int WIDTH = 48,
  parameter int N_IN = 8,
  localparam int LEVELS = levels_of(N_IN),
  localparam int SW = WIDTH + LEVELS,
  localparam int PW = max1(LEVELS - 1)
) (
  input  logic [SW-1:0] slot [N_IN],
  input  logic [PW-1:0] pair,
  output logic [SW-1:0] sum
);
  logic [LEVELS-1:0] ia, ib;
  assign ia = LEVELS'({pair, 1'b0});
  assign ib = LEVELS'({pair, 1'b1});
  assign sum = slot[ia] + slot[ib];
endmodule

// File: rtl/adder_tree_seq_reducer.sv
// adder_tree_seq_reducer: reduces N_IN operands pairwise in place through one shared adder
module adder_tree_seq_reducer import adder_tree_pkg::*; #(
  parameter int WIDTH = 48,
  parameter int N_IN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  adder_tree_seq_reducer_if.slave bus,
  output logic busy
);
  localparam int LEVELS = levels_of(N_IN);
  localparam int SW = WIDTH + LEVELS;
  localparam int PW = max1(LEVELS - 1);
  localparam int LW = max1($clog2(LEVELS));
  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
    $error("N_IN must be a power of two >= 2");
  end
  state_t state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [SW-1:0] slot_q [N_IN];
  logic [SW-1:0] slot_d [N_IN];
  logic [SW-1:0] out_sum_q, out_sum_d;
  logic [SW-1:0] sum;
  logic [LEVELS-1:0] wi;
  logic pair_last, level_last;
  adder_tree_seq_alu #(.WIDTH(WIDTH), .N_IN(N_IN)) u_alu (.slot(slot_q), .pair(pair_q), .sum(sum));
  always_comb begin
    pair_last = pair_q == PW'((N_IN >> (level_q + 1)) - 1);
    level_last = level_q == LW'(LEVELS - 1);
    wi = LEVELS'(pair_q);
    state_d = state_q;
    level_d = level_q;
    pair_d = pair_q;
    slot_d = slot_q;
    out_sum_d = out_sum_q;
    if (flush) begin
      state_d = ST_IDLE;
      level_d = '0;
      pair_d = '0;
    end else if (state_q == ST_IDLE && bus.in_valid) begin
      for (int k = 0; k < N_IN; k++) slot_d[k] = SW'(bus.in_data[k*WIDTH +: WIDTH]);
      level_d = '0;
      pair_d = '0;
      state_d = ST_REDUCE;
    end else if (state_q == ST_REDUCE) begin
      slot_d[wi] = sum;
      pair_d = pair_last ? '0 : pair_q + 1'b1;
      level_d = (pair_last && !level_last) ? level_q + 1'b1 : level_q;
      out_sum_d = (pair_last && level_last) ? sum : out_sum_q;
      state_d = (pair_last && level_last) ? ST_DONE : ST_REDUCE;
    end else if (state_q == ST_DONE && bus.out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      pair_q <= '0;
      out_sum_q <= '0;
      for (int k = 0; k < N_IN; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pair_q <= pair_d;
      out_sum_q <= out_sum_d;
      slot_q <= slot_d;
    end
  end
  assign bus.in_ready = rst_n && state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.out_sum = out_sum_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_adder_tree_seq_reducer.sv
// tb_adder_tree_seq_reducer: vector table plus hand sequences for flush, reset and back-to-back
module tb_adder_tree_seq_reducer;
  localparam int W = 48;
  localparam int N = 8;
  localparam int SW = 51;
  localparam int DW = N * W;
  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] e;
    int hold;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic busy;
  int vectors = 0;
  int miscompares = 0;
  logic [SW-1:0] sb [$];
  vec_t tbl [6];
  adder_tree_seq_reducer_if #(.WIDTH(W), .N_IN(N)) bus ();
  adder_tree_seq_reducer #(.WIDTH(W), .N_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mk(input logic [W-1:0] b, input logic [W-1:0] s);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = b + W'(k) * s;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(input string nm);
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 1, 0);
    else chk(nm, 64'(bus.out_sum), 64'(sb.pop_front()));
  endtask
  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] e, input int hold);
    int n;
    logic [SW-1:0] held;
    n = 0;
    bus.in_data = d;
    bus.in_valid = 1;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    chk("accept_timeout", 64'(n < 50), 1);
    tick();
    bus.in_valid = 0;
    sb.push_back(e);
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    chk("latency", 64'(n), 7);
    held = bus.out_sum;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(bus.out_valid), 1);
      chk("hold_sum", 64'(bus.out_sum), 64'(held));
      chk("hold_in_ready", 64'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    pop_chk("sum");
    tick();
    bus.out_ready = 0;
    chk("valid_one_cycle", 64'(bus.out_valid), 0);
    chk("idle_in_ready", 64'(bus.in_ready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, got, highs;
    int acc_at [2];
    tbl[0] = '{mk(48'd1, 48'd1), 51'd36, 0};
    tbl[1] = '{mk(48'hFFFF_FFFF_FFFF, 48'd0), 51'h7_FFFF_FFFF_FFF8, 0};
    tbl[2] = '{mk(48'd1, 48'd1), 51'd36, 5};
    tbl[3] = '{mk(48'd0, 48'd1), 51'd28, 2};
    tbl[4] = '{mk(48'h1000_0000_0001, 48'h1000_0000_0001), 51'h2_4000_0000_0024, 0};
    tbl[5] = '{mk(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF), 51'h7_FFFF_FFFF_FFDC, 1};
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_sum", 64'(bus.out_sum), 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_in_ready", 64'(bus.in_ready), 1);
    for (int i = 0; i < 6; i++) send(tbl[i].d, tbl[i].e, tbl[i].hold);
    // flush on the third reduce cycle: no result may appear afterwards
    bus.in_data = mk(48'd1, 48'd1);
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    chk("flush_busy_before", 64'(busy), 1);
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_busy", 64'(busy), 0);
    chk("flush_in_ready", 64'(bus.in_ready), 1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin tick(); highs += int'(bus.out_valid); end
    chk("flush_no_output", 64'(highs), 0);
    flush = 1;
    bus.in_valid = 1;
    tick();
    flush = 0;
    bus.in_valid = 0;
    chk("flush_beats_accept", 64'(busy), 0);
    send(mk(48'd0, 48'd1), 51'd28, 0);
    // asynchronous reset mid-reduce
    bus.in_data = mk(48'd5, 48'd3);
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("async_in_ready", 64'(bus.in_ready), 0);
    chk("async_out_valid", 64'(bus.out_valid), 0);
    chk("async_busy", 64'(busy), 0);
    chk("async_out_sum", 64'(bus.out_sum), 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("async_release_ready", 64'(bus.in_ready), 1);
    send(mk(48'd1, 48'd1), 51'd36, 0);
    // in_valid held high across two vectors
    acc = 0;
    got = 0;
    acc_at[0] = 0;
    acc_at[1] = 0;
    bus.in_data = mk(48'd1, 48'd1);
    bus.in_valid = 1;
    bus.out_ready = 1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_at[acc] = c;
        sb.push_back(acc == 0 ? 51'd36 : 51'd28);
        acc++;
      end
      if (bus.out_valid) begin pop_chk("b2b_sum"); got++; end
      tick();
      if (acc == 1) bus.in_data = mk(48'd0, 48'd1);
      if (acc == 2) bus.in_valid = 0;
    end
    bus.out_ready = 0;
    chk("b2b_results", 64'(got), 2);
    chk("b2b_spacing", 64'(acc_at[1] - acc_at[0]), 9);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
